// File: rtl/serial_frame_rx.sv
// serial_frame_rx: preamble-hunting serial receiver with even-parity check.
// Delivers each good payload with a one-cycle valid pulse and counts frames.
module serial_frame_rx #(
    parameter int          DATA_W = 8,
    parameter logic [3:0]  PRE    = 4'b0111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              din,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              err,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_t;

    state_t            state, state_d;
    logic [3:0]        pre_sr, pre_d;
    logic [3:0]        win;
    logic [CW-1:0]     bit_cnt, cnt_d;
    logic [DATA_W-1:0] shift, shift_d;
    logic [DATA_W-1:0] data_d;
    logic              valid_d, err_d, busy_d;
    logic [7:0]        fcnt_d;
    logic              ok;

    // Register bank: all state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            pre_sr    <= 4'b1111;
            bit_cnt   <= '0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_d;
            pre_sr    <= pre_d;
            bit_cnt   <= cnt_d;
            shift     <= shift_d;
            data_out  <= data_d;
            valid     <= valid_d;
            err       <= err_d;
            busy      <= busy_d;
            frame_cnt <= fcnt_d;
        end
    end

    // Next-state logic: hold on en=0, pulses always drop back to 0.
    always_comb begin
        state_d = state;
        pre_d   = pre_sr;
        cnt_d   = bit_cnt;
        shift_d = shift;
        data_d  = data_out;
        fcnt_d  = frame_cnt;
        valid_d = 1'b0;
        err_d   = 1'b0;
        win     = {pre_sr[2:0], din};
        ok      = ~(^shift ^ din);
        if (en) begin
            unique case (state)
                HUNT: begin
                    pre_d = win;
                    if (win == PRE) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
                DATA: begin
                    shift_d = {shift[DATA_W-2:0], din};
                    cnt_d   = bit_cnt + 1'b1;
                    if (bit_cnt == CW'(DATA_W - 1))
                        state_d = PARITY;
                end
                PARITY: begin
                    if (ok) begin
                        data_d  = shift;
                        valid_d = 1'b1;
                        fcnt_d  = frame_cnt + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = HUNT;
                    pre_d   = 4'b1111;
                end
                default: begin
                    state_d = HUNT;
                    pre_d   = 4'b1111;
                end
            endcase
        end
        busy_d = (state_d != HUNT);
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: scoreboard bench for serial_frame_rx.
// A bit-stream model queues expected frames; a monitor checks pulses.
module tb_serial_frame_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          din = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid;
    logic          err;
    logic          busy;
    logic [7:0]    frame_cnt;

    serial_frame_rx #(.DATA_W(DW), .PRE(4'b0111)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .din(din),
        .data_out(data_out),
        .valid(valid),
        .err(err),
        .busy(busy),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            e;
        logic [DW-1:0] d;
        logic [7:0]    c;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;
    int   nvalid = 0;
    bit   prev_pulse = 0;

    // Reference model state: recent bits while hunting, frame bits after.
    bit            hq[$];
    bit            fq[$];
    bit            collecting = 0;
    logic [DW-1:0] m_last = '0;
    int            m_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        fq.delete();
        collecting = 0;
        m_last = '0;
        m_cnt = 0;
        sbq.delete();
    endtask

    task automatic model_bit(bit b);
        logic [DW-1:0] pay;
        int ones;
        exp_t x;
        if (!collecting) begin
            hq.push_back(b);
            if (hq.size() > 4) void'(hq.pop_front());
            if (hq.size() == 4 && hq[0] == 0 && hq[1] == 1 &&
                hq[2] == 1 && hq[3] == 1) begin
                collecting = 1;
                hq.delete();
                fq.delete();
            end
        end else begin
            fq.push_back(b);
            if (fq.size() == DW + 1) begin
                pay = '0;
                ones = 0;
                for (int i = 0; i < DW + 1; i++) ones += fq[i];
                for (int i = 0; i < DW; i++) pay = (pay << 1) | DW'(fq[i]);
                if (ones % 2 == 0) begin
                    m_cnt = (m_cnt + 1) % 256;
                    m_last = pay;
                    x.e = 0;
                end else begin
                    x.e = 1;
                end
                x.d = m_last;
                x.c = 8'(m_cnt);
                sbq.push_back(x);
                collecting = 0;
                fq.delete();
                hq.delete();
            end
        end
    endtask

    // Monitor: every valid/err pulse pops and checks one expectation.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n) begin
            if (valid && err) chk("valid_err_excl", 1, 0);
            if ((valid || err) && prev_pulse) chk("pulse_len", 2, 1);
            if (valid) nvalid++;
            if (valid || err) begin
                chk("sb_nonempty", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    x = sbq.pop_front();
                    chk("kind_err", 32'(err), 32'(x.e));
                    chk("data_out", 32'(data_out), 32'(x.d));
                    chk("frame_cnt", 32'(frame_cnt), 32'(x.c));
                end
            end
            prev_pulse = valid || err;
        end else begin
            prev_pulse = 0;
        end
    end

    task automatic tick(bit e, bit b);
        en = e;
        din = b;
        @(posedge clk);
        #1;
        if (e) model_bit(b);
    endtask

    task automatic do_reset();
        tick(0, 0);
        rst_n = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic send_pre();
        tick(1, 0);
        tick(1, 1);
        tick(1, 1);
        tick(1, 1);
    endtask

    task automatic send_frame(logic [DW-1:0] d, bit bad);
        send_pre();
        for (int i = DW - 1; i >= 0; i--) tick(1, d[i]);
        tick(1, (^d) ^ bad);
    endtask

    task automatic rtick(bit b);
        if ($urandom_range(0, 3) == 0) tick(0, 1'($urandom));
        tick(1, b);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] a5;
        logic [10:0]   s3;
        int            nv0;
        int            ng;
        bit            bad;

        do_reset();
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);

        // Good frame A5
        a5 = 8'hA5;
        tick(1, 0);
        tick(1, 1);
        tick(1, 1);
        chk("t1_busy_pre", 32'(busy), 0);
        tick(1, 1);
        chk("t1_busy_after_pre", 32'(busy), 1);
        for (int i = DW - 1; i >= 0; i--) tick(1, a5[i]);
        tick(1, 0);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_err", 32'(err), 0);
        chk("t1_data", 32'(data_out), 32'h A5);
        chk("t1_cnt", 32'(frame_cnt), 1);
        chk("t1_busy_end", 32'(busy), 0);
        tick(1, 1);
        chk("t1_valid_drop", 32'(valid), 0);

        // Bad parity
        do_reset();
        send_frame(8'hA5, 1);
        chk("t2_err", 32'(err), 1);
        chk("t2_valid", 32'(valid), 0);
        chk("t2_data", 32'(data_out), 0);
        chk("t2_cnt", 32'(frame_cnt), 0);

        // Sliding window: 1,1,1,1,1,0,1,0,1,1,1
        do_reset();
        s3 = 11'b11111010111;
        for (int i = 10; i >= 0; i--) begin
            tick(1, s3[i]);
            chk("t3_busy", 32'(busy), 32'(i == 0));
        end

        // Stall of three cycles inside a good FF frame
        do_reset();
        send_pre();
        tick(1, 1);
        tick(1, 1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0);
            chk("t4_busy_stall", 32'(busy), 1);
        end
        for (int i = 0; i < 6; i++) tick(1, 1);
        tick(1, 0);
        chk("t4_valid", 32'(valid), 1);
        chk("t4_data", 32'(data_out), 32'h FF);

        // Async reset mid-frame
        send_pre();
        for (int i = 0; i < 5; i++) tick(1, 1);
        rst_n = 0;
        model_reset();
        #1;
        chk("t5_async_data", 32'(data_out), 0);
        chk("t5_async_busy", 32'(busy), 0);
        chk("t5_async_cnt", 32'(frame_cnt), 0);
        #2;
        rst_n = 1;
        send_frame(8'h5A, 0);
        chk("t5_cnt_after", 32'(frame_cnt), 1);

        // Frame counter wrap
        do_reset();
        tick(1, 1);
        nv0 = nvalid;
        for (int i = 0; i < 255; i++) send_frame(8'h3C, 0);
        chk("t6_cnt_255", 32'(frame_cnt), 255);
        send_frame(8'h3C, 0);
        chk("t6_cnt_wrap", 32'(frame_cnt), 0);
        tick(1, 1);
        chk("t6_pulses", 32'(nvalid - nv0), 256);

        // Randomized frames with garbage and stalls
        do_reset();
        for (int f = 0; f < 60; f++) begin
            ng = $urandom_range(0, 6);
            for (int g = 0; g < ng; g++) rtick(1'($urandom));
            d = DW'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            rtick(0);
            rtick(1);
            rtick(1);
            rtick(1);
            for (int i = DW - 1; i >= 0; i--) rtick(d[i]);
            rtick((^d) ^ bad);
        end
        for (int i = 0; i < DW + 6; i++) tick(1, 1);
        for (int i = 0; i < 3; i++) tick(0, 0);
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the single-bit serial stream driven on the pre-lab FSM's data input (one bit per clk).
- Hunts for the 4-bit preamble 0111 and shifts in a DATA_W-bit payload MSB-first.
- Checks an even-parity bit, then presents the byte with a one-cycle valid or error pulse.
- Keeps a wrapping count of good frames for bench and debug observation.

Parameters:
DATA_W, 8, payload width in bits (legal range 2..16)
PRE, 4'b0111, preamble pattern, oldest bit first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sample qualifier; din is consumed only on edges where en=1
din  input  1  serial data bit
data_out  output  DATA_W  last good payload
valid  output  1  one-cycle pulse: good frame delivered on data_out
err  output  1  one-cycle pulse: parity failure
busy  output  1  1 while state is DATA or PARITY
frame_cnt  output  8  count of good frames, wraps 255->0

Behaviour:
- Reset (async, rst_n=0) drives every register immediately:
  - state=HUNT, pre_sr=4'b1111, bit_cnt=0, shift=0.
  - data_out=0, valid=0, err=0, busy=0, frame_cnt=0.
  - Reset mid-frame aborts the frame; no valid or err is produced.
- All state changes occur on the rising clk edge with rst_n=1.
- en=0 edge:
  - state, pre_sr, bit_cnt, shift and data_out hold.
  - valid and err still clear, so a pulse never lasts more than one cycle.
- State HUNT (busy=0):
  - On each en edge, pre_sr <= {pre_sr[2:0], din}.
  - If {pre_sr[2:0], din} == PRE, go to DATA with bit_cnt=0 and shift=0.
  - Detection is sliding-window. Example: stream 0,1,0,1,1,1 matches on the final 1.
  - pre_sr reset value 1111 prevents a false match on the first three bits after reset.
- State DATA (busy=1):
  - On each en edge, shift <= {shift[DATA_W-2:0], din} and bit_cnt++.
  - On the edge that samples bit DATA_W-1 (bit_cnt==DATA_W-1), go to PARITY.
- State PARITY (busy=1):
  - On the en edge, ok = (^shift ^ din)==0, i.e. even parity over payload plus parity bit.
  - If ok: data_out<=shift, valid<=1, frame_cnt<=frame_cnt+1 (mod 256).
  - If not ok: err<=1; data_out and frame_cnt hold.
  - In both cases: state<=HUNT, pre_sr<=4'b1111.
  - Payload bits are never reused for preamble detection.
- Latency:
  - valid/err are high in the cycle immediately following the edge that sampled the parity bit.
  - Minimum frame length is 4+DATA_W+1 sampled bits.
  - Back-to-back frames are legal: the next preamble may begin on the edge right after the parity edge.
- valid and err are mutually exclusive and never both 1.
- busy is the registered decode of state.

Test Plan:
- Reset then en=1, din stream 0,1,1,1, 1,0,1,0,0,1,0,1, 0 -> busy=1 from the edge after the 4th bit; after the 13th edge data_out=8'hA5, valid=1 for exactly one cycle, err=0, frame_cnt=1, busy=0.
- Same stream with parity bit 1 -> err=1 for one cycle, valid=0, data_out=8'h00, frame_cnt=0.
- Stream 1,1,1,1,1,0,1,0,1,1,1 -> no match until the final 1 (window 0111), then busy=1; first three bits after reset give no false detect.
- Good frame 8'hFF (parity 0) with en=0 for 3 cycles inserted after the 2nd payload bit -> state holds during the stall; data_out=8'hFF and valid after the parity edge; total cycles = 13 + 3.
- Drive rst_n low for 1 cycle after the 5th payload bit of a frame -> all outputs 0 asynchronously; a complete good frame afterwards gives frame_cnt=1.
- Send 256 consecutive good frames of 8'h3C (parity 0) -> frame_cnt reads 255 then 0, with exactly 256 valid pulses.
